// File: rtl/keypad_scan_axil.sv
// ============================================================================
// keypad_scan_axil : debounced matrix-keypad scanner with AXI4-Lite event FIFO
// Rev 1.0
// ============================================================================
`default_nettype none

module keypad_scan_axil #(
  parameter int ROWS       = 4,
  parameter int COLS       = 4,
  parameter int FIFO_DEPTH = 8,
  parameter int DEB_SCANS  = 3,
  parameter int SETTLE_DEF = 16
) (
  input  logic            ACLK,
  input  logic            ARESET,
  input  logic [3:0]      S_AXI_AWADDR,
  input  logic            S_AXI_AWVALID,
  output logic            S_AXI_AWREADY,
  input  logic [31:0]     S_AXI_WDATA,
  input  logic [3:0]      S_AXI_WSTRB,
  input  logic            S_AXI_WVALID,
  output logic            S_AXI_WREADY,
  output logic [1:0]      S_AXI_BRESP,
  output logic            S_AXI_BVALID,
  input  logic            S_AXI_BREADY,
  input  logic [3:0]      S_AXI_ARADDR,
  input  logic            S_AXI_ARVALID,
  output logic            S_AXI_ARREADY,
  output logic [31:0]     S_AXI_RDATA,
  output logic [1:0]      S_AXI_RRESP,
  output logic            S_AXI_RVALID,
  input  logic            S_AXI_RREADY,
  output logic [COLS-1:0] col_n,
  input  logic [ROWS-1:0] row_n,
  output logic            irq
);

  localparam int C_NKEYS = ROWS * COLS;
  localparam int C_AW    = $clog2(FIFO_DEPTH);
  localparam int C_CIW   = (COLS > 1) ? $clog2(COLS) : 1;
  localparam logic [COLS-1:0]    C_COL0  = COLS'(1);
  localparam logic [C_NKEYS-1:0] C_ONE_N = C_NKEYS'(1);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_DRIVE   = 3'd1,
    S_SAMPLE  = 3'd2,
    S_COMPARE = 3'd3,
    S_EMIT    = 3'd4
  } state_t;

  // Control / status registers
  logic        en_q, irq_en_q, ovf_q, irq_q;
  logic [7:0]  settle_q;

  // AXI write/read channel state
  logic        aw_full_q, w_full_q, bvalid_q, rvalid_q;
  logic [3:0]  awaddr_q;
  logic [31:0] wdata_q, rdata_q, rd_d;
  logic [3:0]  wstrb_q;

  // Event FIFO
  logic [8:0]      mem_q [FIFO_DEPTH];
  logic [C_AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [C_AW:0]   count_q, count_d;

  // Scanner
  state_t               state_q;
  logic [C_CIW-1:0]     col_q;
  logic [7:0]           settle_cnt_q;
  logic [C_NKEYS-1:0]   scan_q, prev_q, deb_q, samp_d, diff, lowbit;
  logic [3:0]           stab_q, stab_d;
  logic [7:0]           emit_idx;
  logic                 emit_press, emit_last;
  logic [COLS-1:0]      col_n_q;
  logic [ROWS-1:0]      row_meta_q, row_sync_q;

  logic        aw_hs, w_hs, ar_hs, wr_fire, empty, full, push, push_ok, pop, ovf_clr;
  logic [3:0]  wa;
  logic [31:0] wd;
  logic [3:0]  ws;

  assign S_AXI_AWREADY = ~ARESET & ~aw_full_q & ~bvalid_q;
  assign S_AXI_WREADY  = ~ARESET & ~w_full_q & ~bvalid_q;
  assign S_AXI_ARREADY = ~ARESET & ~rvalid_q;
  assign S_AXI_BVALID  = bvalid_q;
  assign S_AXI_RVALID  = rvalid_q;
  assign S_AXI_RDATA   = rdata_q;
  assign S_AXI_BRESP   = 2'b00;
  assign S_AXI_RRESP   = 2'b00;
  assign col_n         = col_n_q;
  assign irq           = irq_q;

  assign aw_hs   = S_AXI_AWVALID & S_AXI_AWREADY;
  assign w_hs    = S_AXI_WVALID & S_AXI_WREADY;
  assign ar_hs   = S_AXI_ARVALID & S_AXI_ARREADY;
  assign wr_fire = (aw_full_q | aw_hs) & (w_full_q | w_hs);
  assign wa      = aw_full_q ? awaddr_q : S_AXI_AWADDR;
  assign wd      = w_full_q ? wdata_q : S_AXI_WDATA;
  assign ws      = w_full_q ? wstrb_q : S_AXI_WSTRB;
  assign ovf_clr = wr_fire & (wa == 4'h4) & ws[1] & wd[10];

  assign empty   = (count_q == '0);
  assign full    = (count_q == (C_AW + 1)'(FIFO_DEPTH));
  assign pop     = ar_hs & (S_AXI_ARADDR == 4'h8) & ~empty;
  assign push    = en_q & (state_q == S_EMIT);
  // A full FIFO can still accept when a pop frees a slot in the same cycle
  assign push_ok = push & (~full | pop);
  assign count_d = count_q + {{C_AW{1'b0}}, push_ok} - {{C_AW{1'b0}}, pop};

  logic unused_bits;
  assign unused_bits = &{1'b0, wd[31:11], wd[9:8], ws[3:2]};

  always_comb begin
    rd_d = '0;
    case (S_AXI_ARADDR)
      4'h0: rd_d = {30'b0, irq_en_q, en_q};
      4'h4: rd_d = {21'b0, ovf_q, full, empty, 1'b0, 7'(count_q)};
      4'h8: if (!empty) rd_d = {1'b1, 22'b0, mem_q[rd_ptr_q]};
      4'hC: rd_d = {24'b0, settle_q};
      default: rd_d = '0;
    endcase
  end

  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      aw_full_q <= 1'b0;
      w_full_q  <= 1'b0;
      bvalid_q  <= 1'b0;
      rvalid_q  <= 1'b0;
      awaddr_q  <= '0;
      wdata_q   <= '0;
      wstrb_q   <= '0;
      rdata_q   <= '0;
      en_q      <= 1'b0;
      irq_en_q  <= 1'b0;
      settle_q  <= 8'(SETTLE_DEF);
      irq_q     <= 1'b0;
    end else begin
      if (wr_fire) begin
        aw_full_q <= 1'b0;
        w_full_q  <= 1'b0;
        bvalid_q  <= 1'b1;
        if (wa == 4'h0 && ws[0]) begin
          en_q     <= wd[0];
          irq_en_q <= wd[1];
        end
        if (wa == 4'hC && ws[0]) settle_q <= wd[7:0];
      end else begin
        if (aw_hs) begin
          aw_full_q <= 1'b1;
          awaddr_q  <= S_AXI_AWADDR;
        end
        if (w_hs) begin
          w_full_q <= 1'b1;
          wdata_q  <= S_AXI_WDATA;
          wstrb_q  <= S_AXI_WSTRB;
        end
        if (bvalid_q && S_AXI_BREADY) bvalid_q <= 1'b0;
      end
      if (ar_hs) begin
        rvalid_q <= 1'b1;
        rdata_q  <= rd_d;
      end else if (rvalid_q && S_AXI_RREADY) begin
        rvalid_q <= 1'b0;
      end
      irq_q <= irq_en_q & (~empty | ovf_q);
    end
  end

  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      ovf_q    <= 1'b0;
    end else begin
      if (push_ok) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)     rd_ptr_q <= rd_ptr_q + 1'b1;
      count_q <= count_d;
      if (push && !push_ok) ovf_q <= 1'b1;
      else if (ovf_clr)     ovf_q <= 1'b0;
    end
  end

  always_ff @(posedge ACLK) begin
    if (push_ok) mem_q[wr_ptr_q] <= {emit_press, emit_idx};
  end

  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      row_meta_q <= '1;
      row_sync_q <= '1;
    end else begin
      row_meta_q <= row_n;
      row_sync_q <= row_meta_q;
    end
  end

  always_comb begin
    samp_d = scan_q;
    for (int r = 0; r < ROWS; r++)
      for (int c = 0; c < COLS; c++)
        if (col_q == C_CIW'(c)) samp_d[r*COLS + c] = ~row_sync_q[r];
    stab_d = (scan_q != prev_q) ? 4'd1 : ((stab_q == 4'hF) ? 4'hF : stab_q + 4'd1);
    diff   = prev_q ^ deb_q;
    // Isolate the lowest differing key so events leave in ascending index order
    lowbit    = diff & (~diff + C_ONE_N);
    emit_last = ((diff & ~lowbit) == '0);
    emit_press = |(prev_q & lowbit);
    emit_idx  = '0;
    for (int i = C_NKEYS - 1; i >= 0; i--)
      if (diff[i]) emit_idx = 8'(i);
  end

  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      state_q      <= S_IDLE;
      col_q        <= '0;
      settle_cnt_q <= '0;
      scan_q       <= '0;
      prev_q       <= '0;
      deb_q        <= '0;
      stab_q       <= '0;
      col_n_q      <= '1;
    end else if (!en_q) begin
      state_q <= S_IDLE;
      col_q   <= '0;
      scan_q  <= '0;
      stab_q  <= '0;
      col_n_q <= '1;
    end else begin
      case (state_q)
        S_IDLE: begin
          state_q      <= S_DRIVE;
          col_q        <= '0;
          settle_cnt_q <= settle_q;
          col_n_q      <= ~C_COL0;
        end
        S_DRIVE: begin
          if (settle_cnt_q <= 8'd1) state_q <= S_SAMPLE;
          else settle_cnt_q <= settle_cnt_q - 8'd1;
        end
        S_SAMPLE: begin
          scan_q <= samp_d;
          if (col_q == C_CIW'(COLS - 1)) begin
            state_q <= S_COMPARE;
            col_n_q <= '1;
          end else begin
            state_q      <= S_DRIVE;
            col_q        <= col_q + 1'b1;
            settle_cnt_q <= settle_q;
            col_n_q      <= ~(C_COL0 << (col_q + 1'b1));
          end
        end
        S_COMPARE: begin
          stab_q <= stab_d;
          prev_q <= scan_q;
          if (int'(stab_d) >= DEB_SCANS && scan_q != deb_q) begin
            state_q <= S_EMIT;
          end else begin
            state_q      <= S_DRIVE;
            col_q        <= '0;
            settle_cnt_q <= settle_q;
            col_n_q      <= ~C_COL0;
          end
        end
        S_EMIT: begin
          // Debounced state follows each event, so an aborted emit stays consistent
          deb_q <= (deb_q & ~lowbit) | (prev_q & lowbit);
          if (emit_last) begin
            state_q      <= S_DRIVE;
            col_q        <= '0;
            settle_cnt_q <= settle_q;
            col_n_q      <= ~C_COL0;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: doc/keypad_scan_axil.md
KEYPAD_SCAN_AXIL -- requirements
Module: keypad_scan_axil

Interface
REQ-001 SHALL have parameter ROWS, default 4, keypad row count (1..16).
REQ-002 SHALL have parameter COLS, default 4, keypad column count (1..16), ROWS*COLS <= 256.
REQ-003 SHALL have parameter FIFO_DEPTH, default 8, event FIFO entries (power of 2, 2..64).
REQ-004 SHALL have parameter DEB_SCANS, default 3, consecutive identical full scans required to accept a change (1..15).
REQ-005 SHALL have parameter SETTLE_DEF, default 16, reset value of SETTLE register (cycles).
REQ-006 SHALL have port ACLK  in  1  single clock; all logic on rising edge.
REQ-007 SHALL have port ARESET  in  1  synchronous, active-high reset.
REQ-008 SHALL have AXI4-Lite slave ports S_AXI_AW{ADDR[3:0],VALID,READY}, W{DATA[31:0],STRB[3:0],VALID,READY}, B{RESP[1:0],VALID,READY}, AR{ADDR[3:0],VALID,READY}, R{DATA[31:0],RESP[1:0],VALID,READY}.
REQ-009 SHALL have port col_n  out  COLS  column drive, one-hot active-low during scan, all ones otherwise.
REQ-010 SHALL have port row_n  in  ROWS  asynchronous row sense, active-low (pressed = 0).
REQ-011 SHALL have port irq  out  1  level interrupt.

Function
REQ-012 SHALL pass row_n through a 2-flop synchronizer before any use.
REQ-013 SHALL map registers: 0x0 CTRL (b0 EN, b1 IRQ_EN, R/W); 0x4 STATUS (b6:0 COUNT, b8 EMPTY, b9 FULL, b10 OVF sticky, R; write b10=1 clears OVF); 0x8 EVENT (R, pop); 0xC SETTLE (b7:0, R/W).
REQ-014 SHALL honour WSTRB per byte; writes to read-only bits/unmapped addresses ignored; unmapped reads return 0; all RESP = OKAY.
REQ-015 SHALL accept AW and W independently (either order or together), assert BVALID the cycle after both are captured, hold BVALID until BREADY; one write outstanding.
REQ-016 SHALL assert RVALID the cycle after AR handshake, hold RDATA stable until RREADY; one read outstanding; ARREADY low while RVALID high.
REQ-017 SHALL return EVENT as b31 VALID, b8 PRESS(1)/RELEASE(0), b7:0 key index = row*COLS+col; non-empty read pops one entry at AR handshake; empty read returns 0, no pop.
REQ-018 SHALL run scan FSM IDLE -> DRIVE -> SAMPLE -> (DRIVE next column | COMPARE) -> (EMIT | DRIVE column 0).
REQ-019 IDLE: col_n all ones; leaves to DRIVE column 0 when EN=1.
REQ-020 DRIVE: col_n[k]=0, others 1, for max(SETTLE,1) cycles; SAMPLE: latch ~row_n_sync into raw bitmap column k (one cycle).
REQ-021 COMPARE: if raw bitmap equals previous raw bitmap, increment stable counter (saturating), else reset counter to 1 and store raw; when counter reaches DEB_SCANS and raw differs from debounced bitmap, enter EMIT, else start next scan.
REQ-022 EMIT: push one event per cycle for each bit differing between raw and debounced, ascending key index, then debounced := raw and return to DRIVE column 0.
REQ-023 SHALL, on push while FULL without simultaneous pop, drop the event and set OVF; push and pop in the same cycle when FULL SHALL both succeed, COUNT unchanged.
REQ-024 SHALL drive irq = IRQ_EN & (~EMPTY | OVF), registered.
REQ-025 EN cleared mid-scan SHALL return FSM to IDLE next cycle, col_n all ones, partial raw scan and stable counter discarded, debounced bitmap and FIFO retained.
REQ-026 SETTLE written mid-DRIVE SHALL take effect from the next DRIVE entry.

Reset
REQ-027 ARESET SHALL clear CTRL, OVF, FIFO (EMPTY=1, COUNT=0), raw/debounced bitmaps, stable counter; SETTLE := SETTLE_DEF; FSM := IDLE.
REQ-028 During and after reset: col_n all ones, irq 0, all AXI VALID/READY outputs 0 until first post-reset cycle, BRESP/RRESP 0, RDATA 0.

Verification
REQ-029 Reset, read 0x0/0x4/0xC -> 0x0, 0x100, SETTLE_DEF(0x10); col_n=4'hF, irq=0.
REQ-030 EN=1, hold key row1/col2 pressed 4 scans -> one EVENT read 0x8000_0106; release 4 scans -> 0x8000_0006; next EVENT read -> 0x0.
REQ-031 Key bounce toggling every scan for 10 scans, DEB_SCANS=3 -> no events, COUNT=0.
REQ-032 Press keys 0 and 15 together, stable -> events 0x8000_0100 then 0x8000_010F in order.
REQ-033 Generate 9 events with FIFO_DEPTH=8, no reads -> STATUS FULL=1, OVF=1, COUNT=8; IRQ_EN=1 -> irq=1; write 0x4 b10=1 and drain 8 -> irq=0.
REQ-034 Clear EN while DRIVE on column 2 -> next cycle col_n=4'hF, FSM IDLE, FIFO contents unchanged.
